mest_pro_mem_arbiter: RTL and testbench

Single-port arbiter and access sequencer for the MEST Pro program memory. It shares the one memory port between two requesters: the fetch unit (read-only instruction fetch) and the program loader (host-side reads and writes used to load code before `i_start`). It owns the memory chip-select, write-enable and reset strobes, counts out the memory read latency, and returns data, completion and error per requester. Instantiated between the fetch/loader logic and the program memory macro inside the core top level.

---
 rtl/mest_pro_mem_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_mest_pro_mem_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mest_pro_mem_arbiter.sv
// mest_pro_mem_arbiter
// Shares the single MEST Pro program-memory port between the fetch unit
// and the program loader.
//
// The arbiter owns the memory chip-select, write-enable and reset strobes.
// It counts out the memory read latency and returns data, completion and
// error to whichever requester owned the access. Only one access is ever
// in flight.
//
// Parameters
//   ADDR_W       memory address width
//   DATA_W       instruction/data word width
//   MEM_LATENCY  cycles from CS assertion to valid i_m_rdata (1..7)
//
// Ports
//   clk, i_reset                    clock, synchronous active-high reset
//   i_f_req/i_f_addr                fetch read request and address
//   o_f_gnt/o_f_valid               fetch grant pulse, completion pulse
//   o_f_data/o_f_err                fetch response (held between pulses)
//   i_l_req/i_l_we/i_l_addr/i_l_wdata  loader request, direction, address, data
//   o_l_gnt/o_l_valid               loader grant pulse, completion pulse
//   o_l_rdata/o_l_err               loader response (rdata is 0 for writes)
//   o_m_addr/o_m_wdata/o_m_we/o_m_cs/o_m_reset  registered memory port
//   i_m_rdata/i_m_error             memory read data and error
//   o_busy                          high whenever the FSM is not IDLE
//
// Configuration macro
//   MEST_ARB_FETCH_PRIO_EN  defined: fetch always wins simultaneous requests
//                           undefined: round-robin on a last-winner pointer
module mest_pro_mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 28,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_f_req,
    input  logic [ADDR_W-1:0] i_f_addr,
    output logic              o_f_gnt,
    output logic              o_f_valid,
    output logic [DATA_W-1:0] o_f_data,
    output logic              o_f_err,
    input  logic              i_l_req,
    input  logic              i_l_we,
    input  logic [ADDR_W-1:0] i_l_addr,
    input  logic [DATA_W-1:0] i_l_wdata,
    output logic              o_l_gnt,
    output logic              o_l_valid,
    output logic [DATA_W-1:0] o_l_rdata,
    output logic              o_l_err,
    output logic [ADDR_W-1:0] o_m_addr,
    output logic [DATA_W-1:0] o_m_wdata,
    output logic              o_m_we,
    output logic              o_m_cs,
    output logic              o_m_reset,
    input  logic [DATA_W-1:0] i_m_rdata,
    input  logic              i_m_error,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    // The counter is loaded in ACCESS, so zero means "sample this cycle".
    localparam logic [2:0] LAT_LOAD = 3'(MEM_LATENCY - 1);

    state_t     state;
    state_t     state_next;
    logic       winner;       // owner of the access in flight: 1 = loader
    logic       we_q;         // access in flight is a loader write
    logic [2:0] lat_cnt;
    logic       start;        // accept a request this cycle
    logic       pick_l;       // loader wins the current arbitration
    logic       capture;      // memory response is valid this cycle
    logic       reset_d;

    // Arbitration: a lone request always wins. Ties are broken by the
    // configured policy.
`ifdef MEST_ARB_FETCH_PRIO_EN
    // Fixed priority: the loader only wins when fetch is idle.
    always_comb begin
        pick_l = i_l_req && !i_f_req;
    end
`else
    logic last_l;             // last winner pointer: 1 = loader won last

    // Round-robin: on a tie, the requester that did not win last wins.
    always_comb begin
        pick_l = 1'b0;
        if (i_f_req && i_l_req) begin
            pick_l = !last_l;
        end else begin
            pick_l = i_l_req;
        end
    end

    // The pointer resets to "loader won last", so fetch wins the first tie.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            last_l <= 1'b1;
        end else if (start) begin
            last_l <= pick_l;
        end
    end
`endif

    // Next-state logic.
    // A request raised during RESP is only looked at once the FSM is back
    // in IDLE, which keeps at most one access in flight.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (i_f_req || i_l_req) begin
                    start      = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: state_next = WAIT;
            WAIT: begin
                if (lat_cnt == 3'd0) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register and all registered outputs.
    // The strobes are computed from the next state, so they line up with
    // the state they belong to: gnt and cs appear in ACCESS, valid in RESP.
    // A reset mid-access simply discards the access.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state     <= IDLE;
            winner    <= 1'b0;
            we_q      <= 1'b0;
            lat_cnt   <= 3'd0;
            o_f_gnt   <= 1'b0;
            o_l_gnt   <= 1'b0;
            o_f_valid <= 1'b0;
            o_l_valid <= 1'b0;
            o_f_data  <= '0;
            o_f_err   <= 1'b0;
            o_l_rdata <= '0;
            o_l_err   <= 1'b0;
            o_m_addr  <= '0;
            o_m_wdata <= '0;
            o_m_we    <= 1'b0;
            o_m_cs    <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            state     <= state_next;
            o_f_gnt   <= start && !pick_l;
            o_l_gnt   <= start && pick_l;
            o_m_cs    <= start;
            o_m_we    <= start && pick_l && i_l_we;
            o_busy    <= (state_next != IDLE);
            o_f_valid <= capture && !winner;
            o_l_valid <= capture && winner;

            if (start) begin
                winner    <= pick_l;
                we_q      <= pick_l && i_l_we;
                o_m_addr  <= pick_l ? i_l_addr : i_f_addr;
                o_m_wdata <= pick_l ? i_l_wdata : '0;
            end

            if (state == ACCESS) begin
                lat_cnt <= LAT_LOAD;
            end else if (state == WAIT && lat_cnt != 3'd0) begin
                lat_cnt <= lat_cnt - 3'd1;
            end

            // A write acknowledgement carries zero data but still reports
            // the memory error flag.
            if (capture) begin
                if (winner) begin
                    o_l_rdata <= we_q ? '0 : i_m_rdata;
                    o_l_err   <= i_m_error;
                end else begin
                    o_f_data  <= i_m_rdata;
                    o_f_err   <= i_m_error;
                end
            end
        end
    end

    // Memory reset: held for every reset cycle plus one cycle after
    // i_reset drops, so the macro sees a reset strobe that fully
    // surrounds the arbiter's own reset.
    always_ff @(posedge clk) begin
        reset_d   <= i_reset;
        o_m_reset <= i_reset || reset_d;
    end

endmodule

// File: tb/tb_mest_pro_mem_arbiter.sv
// tb_mest_pro_mem_arbiter
// Directed testbench for mest_pro_mem_arbiter.
//
// Responses are checked with a scoreboard: the expected response for each
// access is queued when the request is driven. A negedge monitor pops and
// compares the entry when the matching valid pulse appears.
//
// A second instance with MEM_LATENCY=3 covers the latency and busy timing.
module tb_mest_pro_mem_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 28;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
    } resp_t;

    logic              clk = 1'b0;
    logic              i_reset;
    logic              i_f_req;
    logic [ADDR_W-1:0] i_f_addr;
    logic              o_f_gnt, o_f_valid, o_f_err;
    logic [DATA_W-1:0] o_f_data;
    logic              i_l_req, i_l_we;
    logic [ADDR_W-1:0] i_l_addr;
    logic [DATA_W-1:0] i_l_wdata;
    logic              o_l_gnt, o_l_valid, o_l_err;
    logic [DATA_W-1:0] o_l_rdata;
    logic [ADDR_W-1:0] o_m_addr;
    logic [DATA_W-1:0] o_m_wdata;
    logic              o_m_we, o_m_cs, o_m_reset, o_busy;
    logic [DATA_W-1:0] i_m_rdata = '0;
    logic              i_m_error = 1'b0;
    logic              err_inject;

    // Second instance (MEM_LATENCY = 3), loader port only.
    logic              s3_l_req, s3_l_we;
    logic [ADDR_W-1:0] s3_l_addr;
    logic [DATA_W-1:0] s3_l_wdata;
    logic              s3_f_gnt, s3_f_valid, s3_f_err;
    logic [DATA_W-1:0] s3_f_data;
    logic              s3_l_gnt, s3_l_valid, s3_l_err;
    logic [DATA_W-1:0] s3_l_rdata;
    logic [ADDR_W-1:0] s3_m_addr;
    logic [DATA_W-1:0] s3_m_wdata;
    logic              s3_m_we, s3_m_cs, s3_m_reset, s3_busy;
    logic [DATA_W-1:0] s3_m_rdata;
    logic [2:0]        s3_pipe = 3'b000;

    resp_t exp_f_q[$];
    resp_t exp_l_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    bit    last_l_model;

    always #5 clk = ~clk;

    mest_pro_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LATENCY(1)) dut (
        .clk(clk), .i_reset(i_reset),
        .i_f_req(i_f_req), .i_f_addr(i_f_addr),
        .o_f_gnt(o_f_gnt), .o_f_valid(o_f_valid), .o_f_data(o_f_data), .o_f_err(o_f_err),
        .i_l_req(i_l_req), .i_l_we(i_l_we), .i_l_addr(i_l_addr), .i_l_wdata(i_l_wdata),
        .o_l_gnt(o_l_gnt), .o_l_valid(o_l_valid), .o_l_rdata(o_l_rdata), .o_l_err(o_l_err),
        .o_m_addr(o_m_addr), .o_m_wdata(o_m_wdata), .o_m_we(o_m_we), .o_m_cs(o_m_cs),
        .o_m_reset(o_m_reset), .i_m_rdata(i_m_rdata), .i_m_error(i_m_error), .o_busy(o_busy)
    );

    mest_pro_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LATENCY(3)) dut3 (
        .clk(clk), .i_reset(i_reset),
        .i_f_req(1'b0), .i_f_addr(16'h0000),
        .o_f_gnt(s3_f_gnt), .o_f_valid(s3_f_valid), .o_f_data(s3_f_data), .o_f_err(s3_f_err),
        .i_l_req(s3_l_req), .i_l_we(s3_l_we), .i_l_addr(s3_l_addr), .i_l_wdata(s3_l_wdata),
        .o_l_gnt(s3_l_gnt), .o_l_valid(s3_l_valid), .o_l_rdata(s3_l_rdata), .o_l_err(s3_l_err),
        .o_m_addr(s3_m_addr), .o_m_wdata(s3_m_wdata), .o_m_we(s3_m_we), .o_m_cs(s3_m_cs),
        .o_m_reset(s3_m_reset), .i_m_rdata(s3_m_rdata), .i_m_error(1'b0), .o_busy(s3_busy)
    );

    // Contents of unwritten memory locations.
    function automatic logic [DATA_W-1:0] dflt(input logic [ADDR_W-1:0] a);
        if (a == 16'h0010) return 28'hABCDEF1;
        return 28'h5A50000 | 28'(a);
    endfunction

    // Memory model for the latency-1 instance.
    // Data and error are registered on the CS cycle and are valid on the
    // next cycle. The read is taken before the write, so a write returns
    // the old contents on i_m_rdata.
    logic [DATA_W-1:0] mem [int];
    always @(posedge clk) begin
        if (o_m_cs) begin
            i_m_rdata <= mem.exists(int'(o_m_addr)) ? mem[int'(o_m_addr)] : dflt(o_m_addr);
            i_m_error <= err_inject;
            if (o_m_we) mem[int'(o_m_addr)] = o_m_wdata;
        end
    end

    // Memory model for the latency-3 instance.
    // Read data is only valid in the third cycle after CS.
    always @(posedge clk) s3_pipe <= {s3_pipe[1:0], s3_m_cs};
    assign s3_m_rdata = s3_pipe[2] ? 28'h3C3C3C3 : 28'h0BAD0BA;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic f_req, input logic [ADDR_W-1:0] f_addr,
                                 input logic l_req, input logic l_we,
                                 input logic [ADDR_W-1:0] l_addr,
                                 input logic [DATA_W-1:0] l_wdata);
        i_f_req   = f_req;
        i_f_addr  = f_addr;
        i_l_req   = l_req;
        i_l_we    = l_we;
        i_l_addr  = l_addr;
        i_l_wdata = l_wdata;
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // One lone request.
    // The request is dropped after its grant, and the FSM is back in IDLE
    // on return.
    task automatic runAccess(input bit is_l, input logic [ADDR_W-1:0] addr,
                             input logic we, input logic [DATA_W-1:0] wdata,
                             input string tag);
        if (is_l) applyStimulus(1'b0, '0, 1'b1, we, addr, wdata);
        else      applyStimulus(1'b1, addr, 1'b0, 1'b0, '0, '0);
        tick();
        checkOutput({tag, "_f_gnt"}, o_f_gnt, !is_l);
        checkOutput({tag, "_l_gnt"}, o_l_gnt, is_l);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        repeat (3) tick();
    endtask

    // Bench model of the arbitration decision.
    function automatic bit predictLoader(input bit f, input bit l);
`ifdef MEST_ARB_FETCH_PRIO_EN
        return l && !f;
`else
        if (f && l) return !last_l_model;
        return l;
`endif
    endfunction

    // Scoreboard monitor.
    // On each valid pulse, pop the oldest expected response for that
    // requester and compare data and error.
    always @(negedge clk) begin
        resp_t e;
        if (o_f_valid) begin
            if (exp_f_q.size() == 0) begin
                checkOutput("f_valid_unexpected", o_f_valid, 1'b0);
            end else begin
                e = exp_f_q.pop_front();
                checkOutput("f_data", o_f_data, e.data);
                checkOutput("f_err", o_f_err, e.err);
            end
        end
        if (o_l_valid) begin
            if (exp_l_q.size() == 0) begin
                checkOutput("l_valid_unexpected", o_l_valid, 1'b0);
            end else begin
                e = exp_l_q.pop_front();
                checkOutput("l_rdata", o_l_rdata, e.data);
                checkOutput("l_err", o_l_err, e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s3_valid_cycle;
        int s3_busy_cnt;
        bit w;

        // ---- reset ----
        i_reset    = 1'b1;
        err_inject = 1'b0;
        s3_l_req   = 1'b0;
        s3_l_we    = 1'b0;
        s3_l_addr  = '0;
        s3_l_wdata = '0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        repeat (3) tick();
        checkOutput("rst_busy", o_busy, 1'b0);
        checkOutput("rst_cs", o_m_cs, 1'b0);
        checkOutput("rst_we", o_m_we, 1'b0);
        checkOutput("rst_f_gnt", o_f_gnt, 1'b0);
        checkOutput("rst_l_valid", o_l_valid, 1'b0);
        checkOutput("rst_m_addr", o_m_addr, 16'h0);
        checkOutput("rst_f_data", o_f_data, 28'h0);
        checkOutput("rst_m_reset", o_m_reset, 1'b1);
        i_reset = 1'b0;
        tick();
        checkOutput("rst_m_reset_tail", o_m_reset, 1'b1);
        tick();
        checkOutput("rst_m_reset_off", o_m_reset, 1'b0);
        last_l_model = 1'b1;

        // ---- single fetch of 0x0010 ----
        exp_f_q.push_back('{data: 28'hABCDEF1, err: 1'b0});
        applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, '0, '0);
        tick();
        checkOutput("fetch_gnt", o_f_gnt, 1'b1);
        checkOutput("fetch_l_gnt", o_l_gnt, 1'b0);
        checkOutput("fetch_cs", o_m_cs, 1'b1);
        checkOutput("fetch_we", o_m_we, 1'b0);
        checkOutput("fetch_addr", o_m_addr, 16'h0010);
        checkOutput("fetch_busy_c1", o_busy, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        tick();
        checkOutput("fetch_gnt_pulse", o_f_gnt, 1'b0);
        checkOutput("fetch_cs_off", o_m_cs, 1'b0);
        checkOutput("fetch_valid_early", o_f_valid, 1'b0);
        tick();
        checkOutput("fetch_valid_c3", o_f_valid, 1'b1);
        checkOutput("fetch_busy_c3", o_busy, 1'b1);
        tick();
        checkOutput("fetch_valid_pulse", o_f_valid, 1'b0);
        checkOutput("fetch_busy_idle", o_busy, 1'b0);
        checkOutput("fetch_data_hold", o_f_data, 28'hABCDEF1);
        last_l_model = 1'b0;

        // ---- loader write 0x1234567 to 0x0002 ----
        exp_l_q.push_back('{data: 28'h0, err: 1'b0});
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 16'h0002, 28'h1234567);
        tick();
        checkOutput("wr_gnt", o_l_gnt, 1'b1);
        checkOutput("wr_we", o_m_we, 1'b1);
        checkOutput("wr_wdata", o_m_wdata, 28'h1234567);
        checkOutput("wr_addr", o_m_addr, 16'h0002);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        tick();
        checkOutput("wr_we_one_cycle", o_m_we, 1'b0);
        tick();
        checkOutput("wr_ack", o_l_valid, 1'b1);
        tick();
        last_l_model = 1'b1;

        // ---- loader read back ----
        exp_l_q.push_back('{data: 28'h1234567, err: 1'b0});
        runAccess(1'b1, 16'h0002, 1'b0, 28'h0, "rd");
        last_l_model = 1'b1;

        // ---- both requests held continuously ----
        applyStimulus(1'b1, 16'h0020, 1'b1, 1'b0, 16'h0021, '0);
        for (int i = 0; i < 4; i++) begin
            w = predictLoader(1'b1, 1'b1);
            if (w) exp_l_q.push_back('{data: dflt(16'h0021), err: 1'b0});
            else   exp_f_q.push_back('{data: dflt(16'h0020), err: 1'b0});
            tick();
            checkOutput($sformatf("tie%0d_f_gnt", i), o_f_gnt, !w);
            checkOutput($sformatf("tie%0d_l_gnt", i), o_l_gnt, w);
            last_l_model = w;
            tick();
            tick();
            tick();
            if (i == 3) applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        end

        // ---- memory error on a fetch, then a clean fetch ----
        err_inject = 1'b1;
        exp_f_q.push_back('{data: dflt(16'h0030), err: 1'b1});
        runAccess(1'b0, 16'h0030, 1'b0, '0, "err");
        err_inject = 1'b0;
        exp_f_q.push_back('{data: dflt(16'h0031), err: 1'b0});
        runAccess(1'b0, 16'h0031, 1'b0, '0, "noerr");
        checkOutput("noerr_f_err_hold", o_f_err, 1'b0);

        // ---- reset during WAIT aborts the access ----
        applyStimulus(1'b1, 16'h0040, 1'b0, 1'b0, '0, '0);
        tick();
        checkOutput("abort_gnt", o_f_gnt, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        tick();
        i_reset = 1'b1;
        tick();
        checkOutput("abort_valid", o_f_valid, 1'b0);
        checkOutput("abort_busy", o_busy, 1'b0);
        checkOutput("abort_m_reset", o_m_reset, 1'b1);
        checkOutput("abort_f_data", o_f_data, 28'h0);
        checkOutput("abort_l_rdata", o_l_rdata, 28'h0);
        checkOutput("abort_m_addr", o_m_addr, 16'h0);
        checkOutput("abort_m_wdata", o_m_wdata, 28'h0);
        tick();
        checkOutput("abort_valid2", o_f_valid, 1'b0);
        i_reset = 1'b0;
        tick();
        checkOutput("abort_m_reset_tail", o_m_reset, 1'b1);
        checkOutput("abort_valid3", o_f_valid, 1'b0);
        tick();
        checkOutput("abort_m_reset_off", o_m_reset, 1'b0);
        last_l_model = 1'b1;

        // ---- first tie after reset goes to fetch, then loader ----
        exp_f_q.push_back('{data: dflt(16'h0050), err: 1'b0});
        applyStimulus(1'b1, 16'h0050, 1'b1, 1'b0, 16'h0051, '0);
        tick();
        checkOutput("post_rst_f_gnt", o_f_gnt, 1'b1);
        checkOutput("post_rst_l_gnt", o_l_gnt, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 16'h0051, '0);
        exp_l_q.push_back('{data: dflt(16'h0051), err: 1'b0});
        repeat (3) tick();
        tick();
        checkOutput("post_rst_l_gnt2", o_l_gnt, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        repeat (3) tick();

        checkOutput("f_queue_drained", exp_f_q.size(), 0);
        checkOutput("l_queue_drained", exp_l_q.size(), 0);

        // ---- MEM_LATENCY = 3 loader read ----
        s3_valid_cycle = 0;
        s3_busy_cnt    = 0;
        s3_l_req       = 1'b1;
        s3_l_addr      = 16'h0005;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (s3_l_gnt) s3_l_req = 1'b0;
            if (s3_busy) s3_busy_cnt++;
            if (s3_l_valid && s3_valid_cycle == 0) begin
                s3_valid_cycle = k;
                checkOutput("lat3_rdata", s3_l_rdata, 28'h3C3C3C3);
            end
        end
        checkOutput("lat3_valid_cycle", s3_valid_cycle, 5);
        checkOutput("lat3_busy_cycles", s3_busy_cnt, 5);
        checkOutput("lat3_req_granted", s3_l_req, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
